vga_board_capture: RTL and testbench

Receive-side companion to the Game-of-Life VGA generator. The block consumes the 8-bit VGA pin bundle as driven on `uo_out`, locks to 640x480@60 (800x525 clocks) timing, and samples the centre pixel of each of the 64 board cells. At every frame end it publishes the recovered 8x8 board as a 64-bit word. It sits in the verification harness and self-check build, on the same pixel clock as the generator, and lets the board state be checked without a frame grabber.

---
 rtl/vga_board_capture.sv | 144 ++++++++++++++
 tb/tb_vga_board_capture.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_board_capture.sv
// rtl/vga_board_capture.sv - recovers the 8x8 Game-of-Life board from a VGA pin stream
module vga_board_capture #(
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter int H_BACK          = 48,
    parameter int V_BACK          = 33,
    parameter int CELL_SIZE       = 50,
    parameter int X_ORG           = 120,
    parameter int Y_ORG           = 40,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  vga_in,
    output logic [63:0] board,
    output logic        board_valid,
    output logic        board_changed,
    output logic        locked,
    output logic        pixel_error,
    output logic [15:0] frame_count
);
    localparam logic       POL     = (SYNC_ACTIVE_LOW != 0);
    localparam logic [9:0] CELL    = 10'(CELL_SIZE);
    // h is cleared one cycle after the deassert word is registered, hence the -1
    localparam logic [9:0] H_FIRST = 10'(H_BACK + X_ORG + CELL_SIZE / 2 - 1);
    localparam logic [9:0] V_FIRST = 10'(V_BACK + Y_ORG + CELL_SIZE / 2);

    logic        hs_q, hs_d, vs_q, vs_d, hs_prev_q, vs_prev_q;
    logic [5:0]  rgb_q, rgb_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic        line_bad_q, line_bad_d, meas_q, meas_d, locked_q, locked_d;
    logic [9:0]  sx_q, sx_d, sy_q, sy_d;
    logic [3:0]  scol_q, scol_d, srow_q, srow_d;
    logic [63:0] shadow_q, shadow_d, board_q, board_d;
    logic [6:0]  scnt_q, scnt_d;
    logic        err_q, err_d, perr_q, perr_d;
    logic        valid_q, valid_d, changed_q, changed_d;
    logic [15:0] fc_q, fc_d;
    logic        hs_fall, vs_fall, vs_rise, take, alive, dead;
    logic [1:0]  r, g, b;

    assign hs_d    = vga_in[7] ^ POL;
    assign vs_d    = vga_in[3] ^ POL;
    assign rgb_d   = {vga_in[6:4], vga_in[2:0]};
    assign hs_fall = hs_prev_q & ~hs_q;
    assign vs_fall = vs_prev_q & ~vs_q;
    assign vs_rise = ~vs_prev_q & vs_q;
    assign r       = {rgb_q[0], rgb_q[3]};
    assign g       = {rgb_q[1], rgb_q[4]};
    assign b       = {rgb_q[2], rgb_q[5]};
    assign alive   = (r == 2'b11) && (g == 2'b01) && (b == 2'b00);
    assign dead    = (r == 2'b11) && (g == 2'b11) && (b == 2'b11);
    assign take    = (h_q == sx_q) && !scol_q[3] && (v_q == sy_q) && !srow_q[3];

    always_comb begin
        h_d        = hs_fall ? 10'd0 : ((h_q == 10'h3FF) ? h_q : h_q + 10'd1);
        v_d        = v_q;
        line_bad_d = line_bad_q;
        meas_d     = meas_q | vs_fall;
        locked_d   = locked_q;
        if (vs_fall)
            v_d = 10'd0;
        else if (hs_fall && v_q != 10'h3FF)
            v_d = v_q + 10'd1;
        if (hs_fall && (({1'b0, h_q} + 11'd1) != 11'(H_TOTAL)))
            line_bad_d = 1'b1;
        if (vs_fall) begin
            line_bad_d = 1'b0;
            if (meas_q)
                locked_d = (v_q == 10'(V_TOTAL)) && !line_bad_q;
        end

        sx_d     = sx_q;
        scol_d   = scol_q;
        sy_d     = sy_q;
        srow_d   = srow_q;
        shadow_d = shadow_q;
        scnt_d   = scnt_q;
        err_d    = err_q;
        if (hs_fall) begin
            sx_d   = H_FIRST;
            scol_d = 4'd0;
        end else if (take) begin
            sx_d   = sx_q + CELL;
            scol_d = scol_q + 4'd1;
        end
        if (vs_fall) begin
            sy_d   = V_FIRST;
            srow_d = 4'd0;
        end else if (take && scol_q == 4'd7) begin
            sy_d   = sy_q + CELL;
            srow_d = srow_q + 4'd1;
        end
        if (take) begin
            shadow_d[{srow_q[2:0], scol_q[2:0]}] = alive;
            scnt_d = scnt_q + 7'd1;
            if (!alive && !dead)
                err_d = 1'b1;
        end

        board_d   = board_q;
        valid_d   = 1'b0;
        changed_d = changed_q;
        fc_d      = fc_q;
        perr_d    = perr_q;
        if (vs_rise) begin
            if (locked_q && scnt_q == 7'd64 && !err_q) begin
                board_d   = shadow_q;
                changed_d = (shadow_q != board_q);
                valid_d   = 1'b1;
                fc_d      = fc_q + 16'd1;
            end
            perr_d   = err_q;
            shadow_d = 64'd0;
            scnt_d   = 7'd0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q <= 1'b0;  vs_q <= 1'b0;  hs_prev_q <= 1'b0;  vs_prev_q <= 1'b0;
            rgb_q <= 6'd0; h_q <= 10'd0;  v_q <= 10'd0;
            line_bad_q <= 1'b0; meas_q <= 1'b0; locked_q <= 1'b0;
            sx_q <= 10'd0; sy_q <= 10'd0; scol_q <= 4'd8; srow_q <= 4'd8;
            shadow_q <= 64'd0; scnt_q <= 7'd0; err_q <= 1'b0; perr_q <= 1'b0;
            board_q <= 64'd0; valid_q <= 1'b0; changed_q <= 1'b0; fc_q <= 16'd0;
        end else begin
            hs_q <= hs_d;  vs_q <= vs_d;  hs_prev_q <= hs_q;  vs_prev_q <= vs_q;
            rgb_q <= rgb_d; h_q <= h_d;   v_q <= v_d;
            line_bad_q <= line_bad_d; meas_q <= meas_d; locked_q <= locked_d;
            sx_q <= sx_d;  sy_q <= sy_d;  scol_q <= scol_d; srow_q <= srow_d;
            shadow_q <= shadow_d; scnt_q <= scnt_d; err_q <= err_d; perr_q <= perr_d;
            board_q <= board_d; valid_q <= valid_d; changed_q <= changed_d; fc_q <= fc_d;
        end
    end

    assign board         = board_q;
    assign board_valid   = valid_q;
    assign board_changed = changed_q;
    assign locked        = locked_q;
    assign pixel_error   = perr_q;
    assign frame_count   = fc_q;
endmodule

// File: tb/tb_vga_board_capture.sv
// tb/tb_vga_board_capture.sv - scoreboard bench for vga_board_capture on a reduced raster
module tb_vga_board_capture;
    localparam int H_ACT = 36, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_ACT = 34, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int CELL = 4, XO = 2, YO = 1;

    localparam logic [63:0] BRD_U = 64'h50A8_8888_0609_0909;
    localparam logic [63:0] BRD_H = 64'h0000_0000_3800_0000;
    localparam logic [63:0] BRD_V = 64'h0000_0010_1010_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  vga_in;
    logic [63:0] board;
    logic        board_valid, board_changed, locked, pixel_error;
    logic [15:0] frame_count;

    vga_board_capture #(
        .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .H_BACK(H_BP), .V_BACK(V_BP),
        .CELL_SIZE(CELL), .X_ORG(XO), .Y_ORG(YO), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .vga_in(vga_in), .board(board),
        .board_valid(board_valid), .board_changed(board_changed), .locked(locked),
        .pixel_error(pixel_error), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] b;
        logic        ch;
        logic [15:0] fc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pix(input logic [63:0] b, input int l, input int hc,
                                       input int ec, input int er);
        logic [1:0] r, g, bl;
        logic       hs, vs;
        int         col, row;
        r = 2'b00; g = 2'b00; bl = 2'b00;
        hs = (hc >= H_ACT + H_FP) && (hc < H_ACT + H_FP + H_SYNC);
        vs = (l >= V_ACT + V_FP) && (l < V_ACT + V_FP + V_SYNC);
        if (hc >= XO && hc < XO + 8 * CELL && l >= YO && l < YO + 8 * CELL &&
            (hc - XO) % CELL == CELL / 2 && (l - YO) % CELL == CELL / 2) begin
            col = (hc - XO) / CELL;
            row = (l - YO) / CELL;
            if (b[row * 8 + col]) begin r = 2'b11; g = 2'b01; bl = 2'b00; end
            else                  begin r = 2'b11; g = 2'b11; bl = 2'b11; end
            if (col == ec && row == er) r = 2'b01;
        end
        return {~hs, bl[0], g[0], r[0], ~vs, bl[1], g[1], r[1]};
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_board"}, board, 64'd0);
        check({tag, "_board_valid"}, 64'(board_valid), 64'd0);
        check({tag, "_board_changed"}, 64'(board_changed), 64'd0);
        check({tag, "_locked"}, 64'(locked), 64'd0);
        check({tag, "_pixel_error"}, 64'(pixel_error), 64'd0);
        check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
    endtask

    task automatic run_frame(input logic [63:0] b, input bit pub, input bit ch,
                             input logic [15:0] fc, input int bad_line, input int ec,
                             input int er, input int rst_line, input int exp_lock,
                             input int exp_perr);
        exp_t e;
        if (pub) begin
            e.b = b; e.ch = ch; e.fc = fc;
            sb_q.push_back(e);
        end
        for (int l = 0; l < V_TOT; l++) begin
            for (int hc = 0; hc < H_TOT; hc++) begin
                if (l == bad_line && hc == H_ACT) continue;
                if (l == 5 && hc == 0) begin
                    if (exp_lock >= 0) check("locked", 64'(locked), 64'(exp_lock));
                    if (exp_perr >= 0) check("pixel_error", 64'(pixel_error), 64'(exp_perr));
                end
                vga_in = pix(b, l, hc, ec, er);
                if (l == rst_line && hc == 0) begin
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    reset_checks("midframe_reset");
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (board_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_publish: got board_valid=1 board=%h expected no publish", board);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pub_board", board, e.b);
                check("pub_changed", 64'(board_changed), 64'(e.ch));
                check("pub_frame_count", 64'(frame_count), 64'(e.fc));
            end
        end
    end

    initial begin
        reset  = 1'b1;
        vga_in = 8'h88;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        reset = 1'b0;
        //        board   pub ch  fc     bad  ec  er  rst lock perr
        run_frame(BRD_U, 0, 0, 16'd0,  -1, -1, -1, -1, -1, -1);
        run_frame(BRD_U, 0, 0, 16'd0,  -1, -1, -1, -1,  0, -1);
        run_frame(BRD_U, 1, 1, 16'd1,  -1, -1, -1, -1,  1, -1);
        run_frame(BRD_U, 1, 0, 16'd2,  -1, -1, -1, -1, -1, -1);
        run_frame(BRD_U, 1, 0, 16'd3,  -1, -1, -1, -1, -1, -1);
        run_frame(BRD_U, 1, 0, 16'd4,  -1, -1, -1, -1, -1, -1);
        run_frame(BRD_H, 1, 1, 16'd5,  -1, -1, -1, -1, -1, -1);
        run_frame(BRD_V, 1, 1, 16'd6,  -1, -1, -1, -1, -1, -1);
        run_frame(BRD_H, 1, 1, 16'd7,  -1, -1, -1, -1, -1, -1);
        run_frame(BRD_V, 1, 1, 16'd8,  -1, -1, -1, -1, -1, -1);
        run_frame(BRD_V, 1, 0, 16'd9,  20, -1, -1, -1,  1, -1);
        run_frame(BRD_V, 0, 0, 16'd0,  -1, -1, -1, -1,  0, -1);
        run_frame(BRD_H, 1, 1, 16'd10, -1, -1, -1, -1,  1, -1);
        run_frame(BRD_H, 0, 0, 16'd0,  -1,  3,  4, -1, -1,  0);
        run_frame(BRD_H, 1, 0, 16'd11, -1, -1, -1, -1, -1,  1);
        run_frame(BRD_V, 1, 1, 16'd12, -1, -1, -1, -1, -1,  0);
        run_frame(BRD_V, 0, 0, 16'd0,  -1, -1, -1, 20, -1, -1);
        run_frame(BRD_V, 0, 0, 16'd0,  -1, -1, -1, -1,  0, -1);
        run_frame(BRD_V, 1, 1, 16'd1,  -1, -1, -1, -1,  1, -1);
        run_frame(BRD_H, 1, 1, 16'd2,  -1, -1, -1, -1, -1, -1);
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
